pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter: ADDR_W, default 32, PC width in bits.
REQ-002 Parameter: RESET_VEC, default 32'h0000_0000, first fetch address after reset (ADDR_W bits).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: hold_i  input  1  pipeline freeze; no PC update except redirect capture.
REQ-006 Port: pc_ready_i  input  1  fetch stage accepts pc_o this cycle.
REQ-007 Port: br_valid_i  input  1  branch/jump redirect request.
REQ-008 Port: br_target_i  input  ADDR_W  branch/jump target.
REQ-009 Port: exc_valid_i  input  1  exception/trap redirect request.
REQ-010 Port: exc_target_i  input  ADDR_W  trap vector.
REQ-011 Port: pc_o  output  ADDR_W  current fetch address.
REQ-012 Port: ce_o  output  1  fetch enable; 0 while out of reset sequencing.
REQ-013 Port: pc_valid_o  output  1  pc_o is a live fetch request.
REQ-014 Port: misalign_o  output  1  one-cycle pulse when a redirect target is misaligned.

Function
REQ-015 FSM states SHALL be OFF, RUN and PEND, registered.
REQ-016 OFF: ce_o=0, pc_valid_o=0, pc_o=RESET_VEC; the first cycle after rst deasserts SHALL go to RUN with ce_o=1, pc_valid_o=1, pc_o=RESET_VEC.
REQ-017 RUN: fire = pc_valid_o & pc_ready_i & ~hold_i; on fire pc_o SHALL become pc_o+4 next cycle; otherwise pc_o holds.
REQ-018 Increment SHALL wrap modulo 2^ADDR_W (all-ones-minus-3 + 4 = 0); no overflow flag.
REQ-019 Redirect priority SHALL be exc_valid_i over br_valid_i; the loser is discarded.
REQ-020 Redirect in RUN with hold_i=0 SHALL load the target into pc_o next cycle regardless of pc_ready_i, overriding any increment.
REQ-021 Redirect with hold_i=1 SHALL capture the winning target in a pending register and go to PEND; pc_o holds.
REQ-022 PEND: a new exc_valid_i SHALL overwrite the pending target; a new br_valid_i SHALL overwrite only a pending branch, never a pending exception.
REQ-023 PEND with hold_i=0 SHALL load the pending target into pc_o next cycle and return to RUN; simultaneous fresh redirect in that cycle SHALL win over the pending one by REQ-019 priority.
REQ-024 Target with bits[1:0]!=0 SHALL be rejected: pc_o unchanged, misalign_o=1 for one cycle, state unchanged.
REQ-025 Redirect-to-pc_o latency SHALL be exactly one cycle when hold_i=0.

Reset
REQ-026 rst=1 at any state, including PEND, SHALL next cycle give state OFF, pc_o=RESET_VEC, ce_o=0, pc_valid_o=0, misalign_o=0, pending register cleared.
REQ-027 Redirect inputs asserted during rst SHALL be ignored.

Configuration
REQ-028 Macro PC_GEN_C_EXT_EN: when defined, add input is_c_i (1 bit); fire increments by 2 when is_c_i=1, else 4; misalignment checks only bit[0].
REQ-029 Without PC_GEN_C_EXT_EN: no is_c_i port, step fixed at 4, bits[1:0] checked.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, step constants (4, 2) and the default address width.
REQ-031 One sub-module pc_redirect_arb SHALL implement priority selection, alignment check and the pending register.

Verification
REQ-032 rst high 3 cycles then low -> cycle 1: ce_o=1, pc_o=0x0; ready held high -> 0x4, 0x8, 0xC.
REQ-033 pc_o=0x10, br_valid_i and exc_valid_i same cycle, targets 0x200/0x800 -> next pc_o=0x800, then 0x804.
REQ-034 hold_i=1, br to 0x100, then exc to 0x300, then br to 0x400, release hold -> pc_o=0x300 next cycle.
REQ-035 pc_o=0xFFFF_FFFC, fire -> pc_o=0x0000_0000.
REQ-036 br_target_i=0x102 -> misalign_o=1 one cycle, pc_o unchanged; with PC_GEN_C_EXT_EN, 0x102 accepted and is_c_i=1 steps 0x102->0x104.
REQ-037 rst asserted in PEND with pending 0x500 -> pc_o=RESET_VEC, ce_o=0; after release first pc_o=RESET_VEC, not 0x500.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
// Optional feature macro: PC_GEN_C_EXT_EN (used by pc_gen and pc_redirect_arb).
package pc_gen_pkg;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } pc_state_e;

    localparam int unsigned DefaultAddrW = 32;
    localparam int unsigned StepFull     = 4;
    localparam int unsigned StepHalf     = 2;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbitration: exception-over-branch priority, alignment check, pending target.
// Optional feature macro: PC_GEN_C_EXT_EN relaxes the alignment check to bit 0.
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic              pend_i,
    input  logic              hold_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              exc_valid_i,
    input  logic [ADDR_W-1:0] exc_target_i,
    output logic              sel_valid_o,
    output logic [ADDR_W-1:0] sel_target_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] pend_target_o
);

`ifdef PC_GEN_C_EXT_EN
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(3);
`endif

    logic              fresh_valid;
    logic [ADDR_W-1:0] fresh_target;
    logic              fresh_misalign;
    logic [ADDR_W-1:0] pend_target_d, pend_target_q;
    logic              pend_exc_d, pend_exc_q;

    always_comb begin
        fresh_valid    = exc_valid_i | br_valid_i;
        fresh_target   = exc_valid_i ? exc_target_i : br_target_i;
        fresh_misalign = active_i & fresh_valid & (|(fresh_target & AlignMask));
        sel_valid_o    = active_i & fresh_valid & ~fresh_misalign;
        sel_target_o   = fresh_target;
        misalign_o     = fresh_misalign;

        pend_target_d = pend_target_q;
        pend_exc_d    = pend_exc_q;
        // A pending exception may only be replaced by another exception.
        if (sel_valid_o && hold_i && (!pend_i || exc_valid_i || !pend_exc_q)) begin
            pend_target_d = fresh_target;
            pend_exc_d    = exc_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_target_q <= '0;
            pend_exc_q    <= 1'b0;
        end else begin
            pend_target_q <= pend_target_d;
            pend_exc_q    <= pend_exc_d;
        end
    end

    assign pend_target_o = pend_target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential increment, prioritised redirects, hold-time pending capture.
// Optional feature macro: PC_GEN_C_EXT_EN adds is_c_i for 2-byte steps.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DefaultAddrW,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              pc_ready_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              exc_valid_i,
    input  logic [ADDR_W-1:0] exc_target_i,
`ifdef PC_GEN_C_EXT_EN
    input  logic              is_c_i,
`endif
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              pc_valid_o,
    output logic              misalign_o
);

    pc_state_e         state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              ce_d, ce_q;
    logic              pc_valid_d, pc_valid_q;
    logic              misalign_d, misalign_q;

    logic              sel_valid;
    logic [ADDR_W-1:0] sel_target;
    logic              sel_misalign;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] step;
    logic              fire;

    pc_redirect_arb #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .active_i      (state_q != StOff),
        .pend_i        (state_q == StPend),
        .hold_i        (hold_i),
        .br_valid_i    (br_valid_i),
        .br_target_i   (br_target_i),
        .exc_valid_i   (exc_valid_i),
        .exc_target_i  (exc_target_i),
        .sel_valid_o   (sel_valid),
        .sel_target_o  (sel_target),
        .misalign_o    (sel_misalign),
        .pend_target_o (pend_target)
    );

`ifdef PC_GEN_C_EXT_EN
    assign step = is_c_i ? ADDR_W'(StepHalf) : ADDR_W'(StepFull);
`else
    assign step = ADDR_W'(StepFull);
`endif

    assign fire = pc_valid_q & pc_ready_i & ~hold_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ce_d       = ce_q;
        pc_valid_d = pc_valid_q;
        misalign_d = sel_misalign;

        unique case (state_q)
            StOff: begin
                state_d    = StRun;
                pc_d       = RESET_VEC;
                ce_d       = 1'b1;
                pc_valid_d = 1'b1;
            end
            StRun: begin
                // A rejected target freezes the PC for this cycle, increment included.
                if (!sel_misalign) begin
                    if (sel_valid) begin
                        if (hold_i) begin
                            state_d = StPend;
                        end else begin
                            pc_d = sel_target;
                        end
                    end else if (fire) begin
                        pc_d = pc_q + step;
                    end
                end
            end
            StPend: begin
                if (!sel_misalign && !hold_i) begin
                    pc_d    = sel_valid ? sel_target : pend_target;
                    state_d = StRun;
                end
            end
            default: begin
                state_d    = StOff;
                pc_d       = RESET_VEC;
                ce_d       = 1'b0;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StOff;
            pc_q       <= RESET_VEC;
            ce_q       <= 1'b0;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign ce_o       = ce_q;
    assign pc_valid_o = pc_valid_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default parameters).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_i;
    logic        pc_ready_i;
    logic        br_valid_i;
    logic [31:0] br_target_i;
    logic        exc_valid_i;
    logic [31:0] exc_target_i;
`ifdef PC_GEN_C_EXT_EN
    logic        is_c_i;
`endif
    logic [31:0] pc_o;
    logic        ce_o;
    logic        pc_valid_o;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_i       (hold_i),
        .pc_ready_i   (pc_ready_i),
        .br_valid_i   (br_valid_i),
        .br_target_i  (br_target_i),
        .exc_valid_i  (exc_valid_i),
        .exc_target_i (exc_target_i),
`ifdef PC_GEN_C_EXT_EN
        .is_c_i       (is_c_i),
`endif
        .pc_o         (pc_o),
        .ce_o         (ce_o),
        .pc_valid_o   (pc_valid_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3] = '{32'h4, 32'h8, 32'hC};
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (pc_o !== 32'h0 || ce_o !== 1'b0 || pc_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h ce=%b valid=%b mis=%b want pc=0 ce=0 valid=0 mis=0",
                     pc_o, ce_o, pc_valid_o, misalign_o);
        end
        rst = 1'b0;
        pc_ready_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h0 || ce_o !== 1'b1 || pc_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch: pc=%h ce=%b valid=%b want pc=0 ce=1 valid=1",
                     pc_o, ce_o, pc_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL seq_inc[%0d]: pc=%h want %h", i, pc_o, exp_seq[i]);
            end
        end
    endtask

    task automatic test_priority();
        tick();
        checks++;
        if (pc_o !== 32'h10) begin
            errors++;
            $display("FAIL pc_at_0x10: pc=%h want 00000010", pc_o);
        end
        br_valid_i = 1'b1;  br_target_i  = 32'h200;
        exc_valid_i = 1'b1; exc_target_i = 32'h800;
        tick();
        checks++;
        if (pc_o !== 32'h800) begin
            errors++;
            $display("FAIL exc_over_br: pc=%h want 00000800", pc_o);
        end
        br_valid_i = 1'b0; exc_valid_i = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'h804) begin
            errors++;
            $display("FAIL after_redirect_inc: pc=%h want 00000804", pc_o);
        end
        pc_ready_i = 1'b0;
    endtask

    task automatic test_hold_pend();
        hold_i = 1'b1; pc_ready_i = 1'b1;
        br_valid_i = 1'b1; br_target_i = 32'h100;
        tick();
        checks++;
        if (pc_o !== 32'h804) begin
            errors++;
            $display("FAIL hold_capture_br: pc=%h want 00000804", pc_o);
        end
        br_valid_i = 1'b0;
        exc_valid_i = 1'b1; exc_target_i = 32'h300;
        tick();
        exc_valid_i = 1'b0;
        br_valid_i = 1'b1; br_target_i = 32'h400;
        tick();
        checks++;
        if (pc_o !== 32'h804) begin
            errors++;
            $display("FAIL hold_pc_frozen: pc=%h want 00000804", pc_o);
        end
        br_valid_i = 1'b0; hold_i = 1'b0; pc_ready_i = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'h300) begin
            errors++;
            $display("FAIL pend_exc_kept: pc=%h want 00000300", pc_o);
        end
        pc_ready_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h304) begin
            errors++;
            $display("FAIL run_after_pend: pc=%h want 00000304", pc_o);
        end
        pc_ready_i = 1'b0;
        // A fresh redirect on the release cycle beats the pending one.
        hold_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h600;
        tick();
        hold_i = 1'b0; br_target_i = 32'h700;
        tick();
        checks++;
        if (pc_o !== 32'h700) begin
            errors++;
            $display("FAIL release_fresh_wins: pc=%h want 00000700", pc_o);
        end
        br_valid_i = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'h700) begin
            errors++;
            $display("FAIL no_ready_holds: pc=%h want 00000700", pc_o);
        end
    endtask

    task automatic test_wrap();
        br_valid_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (pc_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_setup: pc=%h want fffffffc", pc_o);
        end
        br_valid_i = 1'b0; pc_ready_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_to_zero: pc=%h want 00000000", pc_o);
        end
        pc_ready_i = 1'b0;
    endtask

    task automatic test_misalign();
        pc_ready_i = 1'b1;
        br_valid_i = 1'b1; br_target_i = 32'h102;
        tick();
`ifdef PC_GEN_C_EXT_EN
        checks++;
        if (pc_o !== 32'h102 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL half_aligned_accept: pc=%h mis=%b want pc=00000102 mis=0",
                     pc_o, misalign_o);
        end
        br_valid_i = 1'b0; is_c_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h104) begin
            errors++;
            $display("FAIL c_step: pc=%h want 00000104", pc_o);
        end
        is_c_i = 1'b0; pc_ready_i = 1'b0;
        tick();
`else
        checks++;
        if (pc_o !== 32'h0 || misalign_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_reject: pc=%h mis=%b want pc=00000000 mis=1",
                     pc_o, misalign_o);
        end
        br_valid_i = 1'b0; pc_ready_i = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'h0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse_end: pc=%h mis=%b want pc=00000000 mis=0",
                     pc_o, misalign_o);
        end
`endif
        // Misaligned exception wins priority, so the aligned branch is dropped too.
        exc_valid_i = 1'b1; exc_target_i = 32'h801;
        br_valid_i = 1'b1;  br_target_i  = 32'h200;
        tick();
        exc_valid_i = 1'b0; br_valid_i = 1'b0;
        checks++;
        if (pc_o === 32'h200 || pc_o === 32'h801 || misalign_o !== 1'b1) begin
            errors++;
            $display("FAIL exc_misalign_reject: pc=%h mis=%b want pc unchanged mis=1",
                     pc_o, misalign_o);
        end
    endtask

    task automatic test_reset_in_pend();
        logic [31:0] pc_before;
        tick();
        pc_before = pc_o;
        hold_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h500;
        tick();
        br_valid_i = 1'b0;
        checks++;
        if (pc_o !== pc_before || ce_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_entry: pc=%h ce=%b want pc=%h ce=1", pc_o, ce_o, pc_before);
        end
        rst = 1'b1; exc_valid_i = 1'b1; exc_target_i = 32'h900;
        tick();
        checks++;
        if (pc_o !== 32'h0 || ce_o !== 1'b0 || pc_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_pend: pc=%h ce=%b valid=%b mis=%b want 0/0/0/0",
                     pc_o, ce_o, pc_valid_o, misalign_o);
        end
        rst = 1'b0; exc_valid_i = 1'b0; hold_i = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'h0 || ce_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first: pc=%h ce=%b want pc=00000000 ce=1", pc_o, ce_o);
        end
        tick();
        checks++;
        if (pc_o !== 32'h0) begin
            errors++;
            $display("FAIL pend_cleared: pc=%h want 00000000", pc_o);
        end
    endtask

    initial begin
        rst = 1'b1; hold_i = 1'b0; pc_ready_i = 1'b0;
        br_valid_i = 1'b0; br_target_i = '0;
        exc_valid_i = 1'b0; exc_target_i = '0;
`ifdef PC_GEN_C_EXT_EN
        is_c_i = 1'b0;
`endif
        test_reset();
        test_priority();
        test_hold_pend();
        test_wrap();
        test_misalign();
        test_reset_in_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
